// File: rtl/sm_motor_pwm_ramp_driver.sv
// Two-motor PWM driver with soft start/stop ramping and a dead-time interlock on reversal.
// Also registers the electromagnet level-shifter drive.
module sm_motor_pwm_ramp_driver #(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_DIV  = 256,
  parameter int RAMP_STEP = 4,
  parameter int DEADTIME  = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          direction,
  input  logic [PWM_BITS-1:0] speed,
  input  logic                pickup,
  output logic [3:0]          mc,
  output logic [1:0]          em,
  output logic                busy
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = $clog2(DEADTIME + 1);
  localparam logic [PW-1:0]       PRE_LAST  = PW'(RAMP_DIV - 1);
  localparam logic [DW-1:0]       DEAD_LAST = DW'(DEADTIME - 1);
  localparam logic [DW-1:0]       DEAD_FULL = DW'(DEADTIME);
  localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(RAMP_STEP);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_RAMP_DN = 2'd2;
  localparam logic [1:0] S_DEAD    = 2'd3;

  localparam logic [1:0] SGN_ZERO = 2'b00;
  localparam logic [1:0] SGN_FWD  = 2'b01;
  localparam logic [1:0] SGN_REV  = 2'b10;

  logic [1:0]          tgtSign  [2];
  logic [PWM_BITS-1:0] tgtSpeed;
  logic [3:0]          decoded;
  logic [PWM_BITS-1:0] cnt;
  logic [PW-1:0]       pre;
  logic                tick;
  logic [1:0]          state    [2];
  logic [1:0]          curSign  [2];
  logic [1:0]          lastSign [2];
  logic [PWM_BITS-1:0] duty     [2];
  logic [DW-1:0]       deadCnt  [2];

  function automatic logic [3:0] decodeDir(input logic [3:0] d);
    case (d)
      4'd1:       return {SGN_FWD,  SGN_FWD};
      4'd2:       return {SGN_FWD,  SGN_ZERO};
      4'd3:       return {SGN_ZERO, SGN_FWD};
      4'd4:       return {SGN_REV,  SGN_REV};
      4'd5:       return {SGN_FWD,  SGN_REV};
      4'd6, 4'd7: return {SGN_REV,  SGN_FWD};
      default:    return {SGN_ZERO, SGN_ZERO};
    endcase
  endfunction

  function automatic logic [PWM_BITS-1:0] rampToward(input logic [PWM_BITS-1:0] cur,
                                                     input logic [PWM_BITS-1:0] tgt);
    if (cur < tgt)      return (tgt - cur <= STEP) ? tgt : cur + STEP;
    else if (cur > tgt) return (cur - tgt <= STEP) ? tgt : cur - STEP;
    else                return cur;
  endfunction

  assign decoded = decodeDir(direction);
  assign tick    = (pre == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgtSign[0] <= SGN_ZERO;
      tgtSign[1] <= SGN_ZERO;
      tgtSpeed   <= '0;
      em         <= 2'b00;
      cnt        <= '0;
      pre        <= '0;
    end else begin
      tgtSign[0] <= decoded[3:2];
      tgtSign[1] <= decoded[1:0];
      tgtSpeed   <= speed;
      em         <= pickup ? 2'b10 : 2'b00;
      cnt        <= cnt + 1'b1;
      pre        <= tick ? '0 : pre + 1'b1;
    end
  end

  // An IDLE motor remembers its last direction and keeps counting, so a quick
  // stop-then-reverse still honours the dead time before the opposite leg fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        state[m]    <= S_IDLE;
        curSign[m]  <= SGN_ZERO;
        lastSign[m] <= SGN_ZERO;
        duty[m]     <= '0;
        deadCnt[m]  <= '0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        case (state[m])
          S_IDLE: begin
            duty[m] <= '0;
            if (tgtSign[m] != SGN_ZERO) begin
              if (lastSign[m] == SGN_ZERO || tgtSign[m] == lastSign[m] || deadCnt[m] == DEAD_FULL) begin
                state[m]   <= S_RUN;
                curSign[m] <= tgtSign[m];
              end else begin
                state[m]   <= S_DEAD;
                deadCnt[m] <= '0;
              end
            end else if (deadCnt[m] != DEAD_FULL) begin
              deadCnt[m] <= deadCnt[m] + 1'b1;
            end
          end
          S_RUN: begin
            if (tgtSign[m] != curSign[m]) state[m] <= S_RAMP_DN;
            else if (tick)                duty[m]  <= rampToward(duty[m], tgtSpeed);
          end
          S_RAMP_DN: begin
            if (tgtSign[m] == curSign[m]) begin
              state[m] <= S_RUN;
            end else if (duty[m] == '0) begin
              curSign[m] <= SGN_ZERO;
              deadCnt[m] <= '0;
              if (tgtSign[m] == SGN_ZERO) begin
                state[m]    <= S_IDLE;
                lastSign[m] <= curSign[m];
              end else begin
                state[m]    <= S_DEAD;
                lastSign[m] <= SGN_ZERO;
              end
            end else if (tick) begin
              duty[m] <= rampToward(duty[m], '0);
            end
          end
          default: begin
            if (deadCnt[m] == DEAD_LAST) begin
              deadCnt[m]  <= '0;
              lastSign[m] <= SGN_ZERO;
              if (tgtSign[m] != SGN_ZERO) begin
                state[m]   <= S_RUN;
                curSign[m] <= tgtSign[m];
              end else begin
                state[m]   <= S_IDLE;
              end
            end else begin
              deadCnt[m] <= deadCnt[m] + 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc <= 4'b0000;
    end else begin
      mc[3] <= (curSign[0] == SGN_FWD) && (cnt < duty[0]);
      mc[2] <= (curSign[0] == SGN_REV) && (cnt < duty[0]);
      mc[1] <= (curSign[1] == SGN_FWD) && (cnt < duty[1]);
      mc[0] <= (curSign[1] == SGN_REV) && (cnt < duty[1]);
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int m = 0; m < 2; m++) begin
      if (state[m] == S_RAMP_DN || state[m] == S_DEAD) busy = 1'b1;
      else if (state[m] == S_RUN && duty[m] != ((tgtSign[m] != SGN_ZERO) ? tgtSpeed : '0)) busy = 1'b1;
    end
  end

endmodule

// File: tb/tb_sm_motor_pwm_ramp_driver.sv
// Self-checking bench for sm_motor_pwm_ramp_driver: directed scenarios plus randomized
// commands checked against a settled-state model, with a continuous leg-interlock monitor.
`timescale 1ns/1ps
module tb_sm_motor_pwm_ramp_driver;

  localparam int PWM_BITS  = 8;
  localparam int RAMP_DIV  = 64;
  localparam int RAMP_STEP = 4;
  localparam int DEADTIME  = 128;
  localparam int PERIOD    = 1 << PWM_BITS;
  localparam int SETTLE_MAX = 12000;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [3:0]          direction = 4'd0;
  logic [PWM_BITS-1:0] speed = '0;
  logic                pickup = 1'b0;
  logic [3:0]          mc;
  logic [1:0]          em;
  logic                busy;

  int assertCount = 0;
  int failCount   = 0;
  int gapChecks   = 0;
  int hiCnt [4];

  // Movement code -> motor sign (+1 fwd, -1 rev, 0 stop) for M1 and M2.
  int sgnM1 [16] = '{0, 1, 1, 0, -1, 1, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0};
  int sgnM2 [16] = '{0, 1, 0, 1, -1, -1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

  sm_motor_pwm_ramp_driver #(
    .PWM_BITS (PWM_BITS),
    .RAMP_DIV (RAMP_DIV),
    .RAMP_STEP(RAMP_STEP),
    .DEADTIME (DEADTIME)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .direction(direction),
    .speed    (speed),
    .pickup   (pickup),
    .mc       (mc),
    .em       (em),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input int dir, input int spd, input int pk);
    @(negedge clk);
    direction = dir[3:0];
    speed     = spd[PWM_BITS-1:0];
    pickup    = pk[0];
  endtask

  task automatic measurePeriod();
    for (int b = 0; b < 4; b++) hiCnt[b] = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) hiCnt[b] += int'(mc[b]);
    end
  endtask

  task automatic waitSettled(input string tag);
    int n = 0;
    waitCycles(3);
    while (busy && n < SETTLE_MAX) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "-settle-timeout"}, int'(n < SETTLE_MAX), 1);
  endtask

  // Settled behaviour: each driven leg is high exactly 'speed' cycles per PWM period.
  task automatic checkSteady(input string tag, input int dir, input int spd, input int pk);
    int expBits [4];
    expBits[3] = (sgnM1[dir] ==  1) ? spd : 0;
    expBits[2] = (sgnM1[dir] == -1) ? spd : 0;
    expBits[1] = (sgnM2[dir] ==  1) ? spd : 0;
    expBits[0] = (sgnM2[dir] == -1) ? spd : 0;
    measurePeriod();
    for (int b = 0; b < 4; b++)
      checkOutput($sformatf("%s-mc%0d-high", tag, b), hiCnt[b], expBits[b]);
    checkOutput({tag, "-busy"}, int'(busy), 0);
    checkOutput({tag, "-em"}, int'(em), pk ? 2 : 0);
  endtask

  // Interlock monitor: no fwd/rev overlap, and at least DEADTIME low cycles before a reversal.
  int cycleNo = 0;
  int lastHigh [4] = '{-1000000, -1000000, -1000000, -1000000};
  logic [3:0] prevMc = 4'b0000;

  always @(negedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) lastHigh[b] = -1000000;
      prevMc = 4'b0000;
    end else begin
      cycleNo++;
      for (int m = 0; m < 2; m++) begin
        int fi = 3 - 2 * m;
        int ri = 2 - 2 * m;
        if (mc[fi] || mc[ri])
          checkOutput(m == 0 ? "overlap-M1" : "overlap-M2", int'(mc[fi] & mc[ri]), 0);
        if (mc[fi] && !prevMc[fi] && lastHigh[ri] > -1000000) begin
          gapChecks++;
          checkOutput(m == 0 ? "deadgap-M1-fwd" : "deadgap-M2-fwd", int'(cycleNo - lastHigh[ri] > DEADTIME), 1);
        end
        if (mc[ri] && !prevMc[ri] && lastHigh[fi] > -1000000) begin
          gapChecks++;
          checkOutput(m == 0 ? "deadgap-M1-rev" : "deadgap-M2-rev", int'(cycleNo - lastHigh[fi] > DEADTIME), 1);
        end
      end
      for (int b = 0; b < 4; b++) if (mc[b]) lastHigh[b] = cycleNo;
      prevMc = mc;
    end
  end

  initial begin
    int found;
    int prevCnt;
    int gapBefore;
    int rDir, rSpd, rPk;

    // Reset state and an asynchronous reset landing mid-ramp
    waitCycles(3);
    checkOutput("reset-mc", int'(mc), 0);
    checkOutput("reset-em", int'(em), 0);
    checkOutput("reset-busy", int'(busy), 0);
    rst = 1'b0;
    applyStimulus(1, 128, 1);
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      @(negedge clk);
      if (mc[3]) found = 1;
    end
    checkOutput("pre-reset-pwm-active", found, 1);
    #3 rst = 1'b1;
    #1;
    checkOutput("async-reset-mc", int'(mc), 0);
    checkOutput("async-reset-em", int'(em), 0);
    checkOutput("async-reset-busy", int'(busy), 0);
    @(negedge clk);
    direction = 4'd0;
    pickup    = 1'b0;
    waitCycles(2);
    rst = 1'b0;
    waitCycles(4);
    checkOutput("post-reset-busy", int'(busy), 0);
    checkSteady("post-reset-idle", 0, 0, 0);

    // Soft start from IDLE: 32 ticks to reach duty 128
    applyStimulus(1, 128, 0);
    waitCycles(31 * RAMP_DIV - 8);
    checkOutput("rampup-still-busy", int'(busy), 1);
    waitCycles(RAMP_DIV + 16);
    checkOutput("rampup-done", int'(busy), 0);
    checkSteady("fwd-128", 1, 128, 0);

    // Reversal through ramp-down and dead time
    gapBefore = gapChecks;
    applyStimulus(4, 128, 0);
    waitSettled("reverse");
    checkSteady("rev-128", 4, 128, 0);
    checkOutput("reverse-deadgap-seen", int'(gapChecks > gapBefore), 1);

    // Speed change within the same direction ramps without dead time
    applyStimulus(1, 200, 0);
    waitSettled("fwd-200");
    checkSteady("fwd-200", 1, 200, 0);
    applyStimulus(1, 100, 0);
    prevCnt = 201;
    for (int p = 0; p < 6; p++) begin
      measurePeriod();
      checkOutput("speed-drop-in-range", int'(hiCnt[3] >= 100 && hiCnt[3] <= 200), 1);
      checkOutput("speed-drop-monotonic", int'(hiCnt[3] <= prevCnt), 1);
      checkOutput("speed-drop-rev-low", hiCnt[2], 0);
      prevCnt = hiCnt[3];
    end
    waitSettled("fwd-100");
    checkSteady("fwd-100", 1, 100, 0);

    // Stop then resume during ramp-down returns to RUN without losing duty
    applyStimulus(1, 128, 0);
    waitSettled("fwd-128b");
    applyStimulus(0, 128, 0);
    waitCycles(3 * RAMP_DIV);
    applyStimulus(1, 128, 0);
    for (int p = 0; p < 3; p++) begin
      measurePeriod();
      checkOutput("resume-no-dead", int'(hiCnt[3] >= 100), 1);
    end
    waitSettled("resume");
    checkSteady("resume-128", 1, 128, 0);

    // Undefined code acts as stop
    applyStimulus(9, 128, 0);
    waitSettled("dir9");
    checkSteady("dir9-stop", 9, 128, 0);

    // Electromagnet: one clock latency, independent of motors
    applyStimulus(2, 80, 0);
    waitSettled("em-setup");
    applyStimulus(2, 80, 1);
    #1 checkOutput("em-on-latency", int'(em), 0);
    @(negedge clk);
    checkOutput("em-on", int'(em), 2);
    checkSteady("em-on-motors", 2, 80, 1);
    applyStimulus(2, 80, 0);
    #1 checkOutput("em-off-latency", int'(em), 2);
    @(negedge clk);
    checkOutput("em-off", int'(em), 0);
    checkSteady("em-off-motors", 2, 80, 0);

    // Randomized commands against the settled-state model
    for (int t = 0; t < 4; t++) begin
      rDir = int'($urandom_range(0, 15));
      rSpd = int'($urandom_range(0, PERIOD - 1));
      rPk  = int'($urandom_range(0, 1));
      applyStimulus(rDir, rSpd, rPk);
      waitSettled($sformatf("rand%0d", t));
      checkSteady($sformatf("rand%0d-d%0d-s%0d", t, rDir, rSpd), rDir, rSpd, rPk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
